inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 168 ++++++++++++++++
 tb/tb_inst_fetch.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch unit: a single-outstanding request/response engine between imem and the decoder.
// Optional fetch counter output is enabled by defining IFU_FETCH_CNT_EN.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
`ifdef IFU_FETCH_CNT_EN
  ,
  output logic [31:0] fetch_cnt
`endif
);

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] S_REQ    = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_FULL   = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] out_inst_q, out_inst_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            kill_q, kill_d;
  logic            pend_q, pend_d;
  logic            halt_pend_q, halt_pend_d;
  logic            req_valid_q, req_valid_d;
  logic            out_valid_q, out_valid_d;

  logic [XLEN-1:0] redir_pc_c;
  logic [1:0]      req_or_halt_c;

  assign redir_pc_c    = {redirect_pc[XLEN-1:2], 2'b00};
  // A pending halt diverts every would-be return to REQ into HALTED.
  assign req_or_halt_c = (halt_pend_q || halt) ? S_HALTED : S_REQ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      out_inst_q  <= '0;
      out_pc_q    <= '0;
      pend_pc_q   <= '0;
      kill_q      <= 1'b0;
      pend_q      <= 1'b0;
      halt_pend_q <= 1'b0;
      req_valid_q <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
      pend_pc_q   <= pend_pc_d;
      kill_q      <= kill_d;
      pend_q      <= pend_d;
      halt_pend_q <= halt_pend_d;
      req_valid_q <= req_valid_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;
    pend_pc_d   = pend_pc_q;
    kill_d      = kill_q;
    pend_d      = pend_q;
    halt_pend_d = halt_pend_q | halt;

    case (state_q)
      S_REQ: begin
        if (redirect_valid) begin
          pend_pc_d = redir_pc_c;
        end
        // The address on the bus stays put until accepted; a redirect only becomes a kill on acceptance.
        if (imem_req_ready) begin
          state_d = S_WAIT;
          if (redirect_valid || pend_q) begin
            kill_d = 1'b1;
            pend_d = 1'b0;
          end
        end else if (redirect_valid) begin
          pend_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pend_pc_d = redir_pc_c;
          kill_d    = 1'b1;
        end
        if (imem_resp_valid) begin
          kill_d = 1'b0;
          if (redirect_valid) begin
            state_d = req_or_halt_c;
            pc_d    = redir_pc_c;
          end else if (kill_q) begin
            state_d = req_or_halt_c;
            pc_d    = pend_pc_q;
          end else begin
            state_d    = S_FULL;
            out_inst_d = imem_resp_data;
            out_pc_d   = pc_q;
          end
        end
      end
      S_FULL: begin
        // A redirect wins over a same-cycle decoder handshake.
        if (redirect_valid) begin
          state_d = req_or_halt_c;
          pc_d    = redir_pc_c;
        end else if (out_ready) begin
          state_d = req_or_halt_c;
          pc_d    = pc_q + XLEN'(4);
        end
      end
      default: begin
        state_d = S_HALTED;
      end
    endcase

    req_valid_d = (state_d == S_REQ);
    out_valid_d = (state_d == S_FULL);
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign out_valid      = out_valid_q;
  assign out_inst       = out_inst_q;
  assign out_pc         = out_pc_q;

`ifdef IFU_FETCH_CNT_EN
  // Counts instructions actually delivered to the decoder.
  logic [XLEN-1:0] fetch_cnt_q;
  logic            deliver_c;

  assign deliver_c = (state_q == S_FULL) && out_ready && !redirect_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
    end else if (deliver_c) begin
      fetch_cnt_q <= fetch_cnt_q + XLEN'(1);
    end
  end

  assign fetch_cnt = fetch_cnt_q;
`else
  // No delivery counter in this build.
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed scenarios plus a randomized run scored against a transaction-level fetch model.
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
`ifdef IFU_FETCH_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  int checks = 0;
  int errors = 0;

  inst_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc)
`ifdef IFU_FETCH_CNT_EN
    ,
    .fetch_cnt      (fetch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Memory image: every word is a fixed scramble of its address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
  endfunction

  logic        mem_busy;
  logic [31:0] mem_addr;
  int          mem_lat;
  logic [31:0] exp_pc;
  int          rand_deliv;
  logic        have_prev, p_rv, p_rr, p_ov, p_or, p_rd;
  logic [31:0] p_addr, p_inst, p_pc;

  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk1("rst_req_valid", imem_req_valid, 1'b1);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
`ifdef IFU_FETCH_CNT_EN
    chk("rst_fetch_cnt", fetch_cnt, 32'd0);
`endif

    // Basic fetch.
    imem_req_ready = 1'b1; tick();
    chk1("t1_wait_no_req", imem_req_valid, 1'b0);
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0010_0093; tick();
    chk1("t1_out_valid", out_valid, 1'b1);
    chk("t1_out_pc", out_pc, 32'h8000_0000);
    chk("t1_out_inst", out_inst, 32'h0010_0093);
    imem_resp_valid = 1'b0; out_ready = 1'b1; tick();
    out_ready = 1'b0;
    chk1("t1_next_req", imem_req_valid, 1'b1);
    chk("t1_next_addr", imem_req_addr, 32'h8000_0004);
    chk1("t1_out_dropped", out_valid, 1'b0);

    // Decoder stall in FULL, with a stray response that must be ignored.
    imem_req_ready = 1'b1; tick();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0020_0113; tick();
    for (int i = 0; i < 5; i++) begin
      chk1("t2_hold_valid", out_valid, 1'b1);
      chk("t2_hold_inst", out_inst, 32'h0020_0113);
      chk("t2_hold_pc", out_pc, 32'h8000_0004);
      chk1("t2_no_req", imem_req_valid, 1'b0);
      imem_resp_valid = (i == 2);
      imem_resp_data = 32'hDEAD_BEEF;
      tick();
    end
    imem_resp_valid = 1'b0;
    chk("t2_hold_inst_end", out_inst, 32'h0020_0113);
    out_ready = 1'b1; tick();
    out_ready = 1'b0;
    chk("t2_next_addr", imem_req_addr, 32'h8000_0008);

    // Redirect during WAIT discards the response.
    imem_req_ready = 1'b1; tick();
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8000_0101; tick();
    redirect_valid = 1'b0;
    chk1("t3_still_wait", imem_req_valid, 1'b0);
    imem_resp_valid = 1'b1; imem_resp_data = 32'h1111_1111; tick();
    imem_resp_valid = 1'b0;
    chk1("t3_discard_valid", out_valid, 1'b0);
    chk1("t3_req_valid", imem_req_valid, 1'b1);
    chk("t3_redir_addr", imem_req_addr, 32'h8000_0100);
    tick();
    chk1("t3_never_valid", out_valid, 1'b0);
    chk("t3_addr_stable", imem_req_addr, 32'h8000_0100);

    // Redirect in FULL beats a same-cycle handshake.
    imem_req_ready = 1'b1; tick();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0030_0193; tick();
    imem_resp_valid = 1'b0;
    chk("t4_out_pc", out_pc, 32'h8000_0100);
    chk("t4_out_inst", out_inst, 32'h0030_0193);
    redirect_valid = 1'b1; redirect_pc = 32'h9000_0002; out_ready = 1'b1; tick();
    redirect_valid = 1'b0; out_ready = 1'b0;
    chk1("t4_out_drop", out_valid, 1'b0);
    chk("t4_redir_addr", imem_req_addr, 32'h9000_0000);
`ifdef IFU_FETCH_CNT_EN
    chk("t4_fetch_cnt", fetch_cnt, 32'd2);
`endif

    // Pending redirect in REQ to the top word, then pc wrap.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; tick();
    redirect_valid = 1'b0;
    chk("t5_req_stable", imem_req_addr, 32'h9000_0000);
    imem_req_ready = 1'b1; tick();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h2222_2222; tick();
    imem_resp_valid = 1'b0;
    chk1("t5_wrong_path_valid", out_valid, 1'b0);
    chk("t5_pending_addr", imem_req_addr, 32'hFFFF_FFFC);
    imem_req_ready = 1'b1; tick();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0040_0213; tick();
    imem_resp_valid = 1'b0;
    chk("t5_top_pc", out_pc, 32'hFFFF_FFFC);
    out_ready = 1'b1; tick();
    out_ready = 1'b0;
    chk("t5_wrap_addr", imem_req_addr, 32'h0000_0000);
`ifdef IFU_FETCH_CNT_EN
    chk("t5_fetch_cnt", fetch_cnt, 32'd3);
`endif

    // Halt while waiting: the in-flight fetch still delivers, then the unit parks.
    imem_req_ready = 1'b1; tick();
    imem_req_ready = 1'b0; halt = 1'b1; tick();
    halt = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0050_0293; tick();
    imem_resp_valid = 1'b0;
    chk1("t6_delivered", out_valid, 1'b1);
    chk("t6_out_pc", out_pc, 32'h0);
    chk("t6_out_inst", out_inst, 32'h0050_0293);
    out_ready = 1'b1; tick();
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk1("t6_halt_no_req", imem_req_valid, 1'b0);
      chk1("t6_halt_no_out", out_valid, 1'b0);
      imem_req_ready = 1'b1;
      redirect_valid = (i == 3);
      redirect_pc = RESET_PC;
      imem_resp_valid = (i == 5);
      tick();
    end
    imem_req_ready = 1'b0; redirect_valid = 1'b0; imem_resp_valid = 1'b0;
`ifdef IFU_FETCH_CNT_EN
    chk("t6_fetch_cnt", fetch_cnt, 32'd4);
`endif

    // Reset in WAIT, late response right after release.
    rst = 1'b1; tick();
    rst = 1'b0;
    chk1("t7_req_valid", imem_req_valid, 1'b1);
    chk("t7_out_inst_cleared", out_inst, 32'h0);
    imem_req_ready = 1'b1; tick();
    imem_req_ready = 1'b0; rst = 1'b1; tick();
    rst = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h3333_3333; tick();
    imem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk1("t7_late_ignored", out_valid, 1'b0);
      chk1("t7_req_held", imem_req_valid, 1'b1);
      chk("t7_req_addr", imem_req_addr, RESET_PC);
      tick();
    end
    imem_req_ready = 1'b1; tick();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0060_0313; tick();
    imem_resp_valid = 1'b0;
    chk("t7_out_pc", out_pc, RESET_PC);
    chk("t7_out_inst", out_inst, 32'h0060_0313);

    // Randomized run: memory, decoder and redirects all random.
    out_ready = 1'b0; rst = 1'b1; tick();
    rst = 1'b0;
    exp_pc = RESET_PC; mem_busy = 1'b0; mem_addr = '0; mem_lat = 0;
    rand_deliv = 0; have_prev = 1'b0;
    p_rv = 1'b0; p_rr = 1'b0; p_ov = 1'b0; p_or = 1'b0; p_rd = 1'b0;
    p_addr = '0; p_inst = '0; p_pc = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (have_prev && p_rv && !p_rr) begin
        chk1("r_req_hold_valid", imem_req_valid, 1'b1);
        chk("r_req_hold_addr", imem_req_addr, p_addr);
      end
      if (have_prev && p_ov && !p_or && !p_rd) begin
        chk1("r_out_hold_valid", out_valid, 1'b1);
        chk("r_out_hold_inst", out_inst, p_inst);
        chk("r_out_hold_pc", out_pc, p_pc);
      end
      if (imem_req_valid) chk("r_addr_align", 32'(imem_req_addr[1:0]), 32'd0);

      if (mem_busy && mem_lat == 0) begin
        imem_resp_valid = 1'b1; imem_resp_data = memf(mem_addr); mem_busy = 1'b0;
      end else if (mem_busy) begin
        imem_resp_valid = 1'b0; mem_lat--;
      end else begin
        imem_resp_valid = ($urandom % 8 == 0);
        imem_resp_data = 32'hBAD0_0000 | 32'(cyc);
      end
      imem_req_ready = ($urandom % 3 != 0);
      out_ready = ($urandom % 2 == 0);
      redirect_valid = ($urandom % 12 == 0);
      redirect_pc = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 + 32'($urandom % 16)) : 32'($urandom);

      if (imem_req_valid && imem_req_ready) begin
        if (mem_busy) chk1("r_mem_overlap", mem_busy, 1'b0);
        mem_busy = 1'b1; mem_addr = imem_req_addr; mem_lat = int'($urandom % 3);
      end
      if (redirect_valid) begin
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else if (out_valid && out_ready) begin
        chk("r_deliver_pc", out_pc, exp_pc);
        chk("r_deliver_inst", out_inst, memf(exp_pc));
        exp_pc = exp_pc + 32'd4;
        rand_deliv++;
      end

      have_prev = 1'b1;
      p_rv = imem_req_valid; p_rr = imem_req_ready; p_addr = imem_req_addr;
      p_ov = out_valid; p_or = out_ready; p_rd = redirect_valid;
      p_inst = out_inst; p_pc = out_pc;
      tick();
    end
    chk1("r_progress", rand_deliv > 100, 1'b1);
`ifdef IFU_FETCH_CNT_EN
    chk("r_fetch_cnt", fetch_cnt, 32'(rand_deliv));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
